deskew_nln: RTL and testbench
=============================

Name: deskew_nln

Overview:
- Parametrised N-lane alignment-marker deskew lock monitor for the SL3 receive path.
- Sits after per-lane word lock and marker detection.
- Compares per-lane marker "pings" in time, and requests a one-word fallback (slip) from any lane whose marker arrives early.
- Declares deskew lock after LOCK_CNT consecutive aligned markers and drops it after UNLOCK_CNT consecutive misaligned events; also reports measured inter-lane skew per marker round.

Parameters:
NUM_LANES, 4, number of lanes (2..16)
GRACE, 8, cycles after a lane's ping during which that lane counts as "recently pinged" (1..255)
LOCK_CNT, 1, consecutive aligned events required to assert lock (1..255)
UNLOCK_CNT, 2, consecutive misaligned events while locked that drop lock (1..255)

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
word_locked  in  1  all lanes word-locked; low acts as reset of lock state
am_ping  in  NUM_LANES  per-lane marker-detected pulse
fallback_req  out  NUM_LANES  per-lane one-cycle slip request
deskew_locked  out  1  lanes deskewed
skew_cycles  out  8  cycles between first and last ping of most recent round
skew_valid  out  1  one-cycle pulse; skew_cycles updated
skew_overflow  out  1  qualifies skew_valid: round timed out before all lanes pinged

Behaviour:
- Reset: srst is synchronous, active-high; clock is clk. During srst, all outputs are 0 and all counters/masks are cleared. Same effect when word_locked=0, except skew_cycles holds its value.
- Input stage: am_ping registered once (am_ping_r); all decisions use am_ping_r. Total latency from am_ping to fallback_req/deskew_locked is 2 cycles.
- Grace counters, one per lane:
  - am_ping_r[i]=1 loads GRACE; otherwise the counter decrements while nonzero.
  - recent[i] = (counter != 0), evaluated before the load, so a lane is not "recent" in its own ping cycle.
- Events: a cycle with am_ping_r != 0 is an event.
  - aligned: &am_ping_r.
  - misaligned: event and not aligned.
- Unlocked state:
  - Aligned event: good_cnt++. When good_cnt reaches LOCK_CNT, deskew_locked<=1 and good_cnt clears.
  - Misaligned event: good_cnt<=0.
  - fallback_req[i] <= recent[i] & ~am_ping_r[i] & |(am_ping_r & ~(1<<i)). Meaning: lane i pinged within the last GRACE cycles and another lane pings now, so lane i is early and must slip.
  - Multiple bits may assert in the same cycle.
- Locked state:
  - fallback_req forced 0.
  - Misaligned event: bad_cnt++. When bad_cnt reaches UNLOCK_CNT, deskew_locked<=0, and bad_cnt and good_cnt clear.
  - Aligned event: bad_cnt<=0.
  - Non-event cycles leave both counters unchanged.
- Skew measurement (runs locked or unlocked):
  - IDLE: an event with no round open opens a round, sets seen_mask=am_ping_r and skew_cnt=0.
  - If the event is aligned, the round closes the same cycle: skew_cycles<=0 and skew_valid=1.
  - OPEN: skew_cnt++ each cycle and seen_mask |= am_ping_r.
    - When seen_mask becomes all-ones: skew_cycles<=skew_cnt+1, skew_valid=1, skew_overflow=0, return to IDLE.
    - If skew_cnt+1 reaches GRACE before completion: skew_cycles<=GRACE, skew_valid=1, skew_overflow=1, return to IDLE.
    - A lane pinging twice in one round is ignored.
  - skew_valid and fallback_req are registered outputs, asserted in the cycle after the triggering am_ping_r cycle.
- Boundaries:
  - Counters saturate, never wrap.
  - A word_locked drop mid-round abandons the round with no skew_valid.
  - srst wins over all events in the same cycle.
  - With NUM_LANES=2, LOCK_CNT=1, UNLOCK_CNT=2, GRACE=8, lock and fallback behaviour equals the existing 2-lane deskew.

Test Plan:
- All 4 lanes ping in the same cycle, LOCK_CNT=1 -> deskew_locked=1 two cycles after am_ping; skew_valid with skew_cycles=0, skew_overflow=0; fallback_req stays 0.
- Unlocked; lane 2 pings 3 cycles before lanes 0,1,3 -> fallback_req=4'b0100 for one cycle; skew_cycles=3; deskew_locked stays 0.
- Locked, UNLOCK_CNT=2; two consecutive misaligned events (lane 3 missing) -> lock drops on the second. Repeat with an aligned event in between -> lock retained.
- Lane 1 never pings after the others with GRACE=8 -> skew_valid with skew_overflow=1 and skew_cycles=8; no fallback_req for lane 1.
- LOCK_CNT=3: aligned, aligned, misaligned, then 3 aligned -> lock asserts only after the final 3rd consecutive aligned event.
- srst asserted, or word_locked dropped, while locked with a round open -> next cycle deskew_locked=0, fallback_req=0, no skew_valid; recovers normally after release.

Source files
------------

// File: rtl/deskew_nln.sv
`timescale 1ns/1ps
// Alignment-marker deskew lock monitor: slips lanes whose marker arrives early,
// tracks deskew lock, and measures inter-lane skew per marker round.
//   state       | meaning
//   LK_UNLOCKED | hunting: counting consecutive aligned markers, slips enabled
//   LK_LOCKED   | deskewed: counting consecutive misaligned markers
//   SK_IDLE     | no skew round open
//   SK_OPEN     | round open, waiting for the remaining lanes to ping
module deskew_nln #(
  parameter int NUM_LANES  = 4,
  parameter int GRACE      = 8,
  parameter int LOCK_CNT   = 1,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 word_locked,
  input  logic [NUM_LANES-1:0] am_ping,
  output logic [NUM_LANES-1:0] fallback_req,
  output logic                 deskew_locked,
  output logic [7:0]           skew_cycles,
  output logic                 skew_valid,
  output logic                 skew_overflow
);
  typedef enum logic {LK_UNLOCKED, LK_LOCKED} lock_state_t;
  typedef enum logic {SK_IDLE, SK_OPEN} skew_state_t;

  localparam logic [7:0] GRACE_V  = 8'(GRACE);
  localparam logic [8:0] GRACE_W  = 9'(GRACE);
  localparam logic [8:0] LOCK_W   = 9'(LOCK_CNT);
  localparam logic [8:0] UNLOCK_W = 9'(UNLOCK_CNT);

  logic                 clr;
  logic [NUM_LANES-1:0] am_ping_r, recent, slip, seen_mask, seen_d, seen_all, fallback_d;
  lock_state_t          lock_q, lock_d;
  skew_state_t          skew_q, skew_d;
  logic [7:0]           good_cnt, good_d, bad_cnt, bad_d, skew_cnt, skew_cnt_d, skew_cycles_d;
  logic                 valid_d, overflow_d, is_event, is_aligned;

  assign clr        = srst | ~word_locked;
  assign is_event   = |am_ping_r;
  assign is_aligned = &am_ping_r;
  assign seen_all   = seen_mask | am_ping_r;

  // recent[] reflects the counter before this cycle's load, so a lane is never
  // early relative to its own ping.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0]           grace_cnt;
    logic [NUM_LANES-1:0] others;

    always_ff @(posedge clk) begin
      if (clr)                   grace_cnt <= '0;
      else if (am_ping_r[i])     grace_cnt <= GRACE_V;
      else if (grace_cnt != '0)  grace_cnt <= grace_cnt - 8'd1;
    end

    always_comb begin
      others    = am_ping_r;
      others[i] = 1'b0;
    end

    assign recent[i] = (grace_cnt != '0);
    assign slip[i]   = recent[i] & ~am_ping_r[i] & (|others);
  end

  always_comb begin
    lock_d     = lock_q;
    good_d     = good_cnt;
    bad_d      = bad_cnt;
    fallback_d = '0;
    case (lock_q)
      LK_UNLOCKED: begin
        fallback_d = slip;
        if (is_aligned) begin
          if ({1'b0, good_cnt} + 9'd1 >= LOCK_W) begin
            lock_d = LK_LOCKED;
            good_d = '0;
          end else if (good_cnt != 8'hFF) begin
            good_d = good_cnt + 8'd1;
          end
        end else if (is_event) begin
          good_d = '0;
        end
      end
      LK_LOCKED: begin
        if (is_aligned) begin
          bad_d = '0;
        end else if (is_event) begin
          if ({1'b0, bad_cnt} + 9'd1 >= UNLOCK_W) begin
            lock_d = LK_UNLOCKED;
            bad_d  = '0;
            good_d = '0;
          end else if (bad_cnt != 8'hFF) begin
            bad_d = bad_cnt + 8'd1;
          end
        end
      end
      default: lock_d = LK_UNLOCKED;
    endcase
  end

  always_comb begin
    skew_d        = skew_q;
    seen_d        = seen_mask;
    skew_cnt_d    = skew_cnt;
    skew_cycles_d = skew_cycles;
    valid_d       = 1'b0;
    overflow_d    = 1'b0;
    case (skew_q)
      SK_IDLE: begin
        if (is_aligned) begin
          skew_cycles_d = '0;
          valid_d       = 1'b1;
        end else if (is_event) begin
          skew_d     = SK_OPEN;
          seen_d     = am_ping_r;
          skew_cnt_d = '0;
        end
      end
      SK_OPEN: begin
        if (&seen_all) begin
          skew_cycles_d = skew_cnt + 8'd1;
          valid_d       = 1'b1;
          skew_d        = SK_IDLE;
        end else if ({1'b0, skew_cnt} + 9'd1 >= GRACE_W) begin
          skew_cycles_d = GRACE_V;
          valid_d       = 1'b1;
          overflow_d    = 1'b1;
          skew_d        = SK_IDLE;
        end else begin
          skew_cnt_d = skew_cnt + 8'd1;
          seen_d     = seen_all;
        end
      end
      default: skew_d = SK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      am_ping_r     <= '0;
      lock_q        <= LK_UNLOCKED;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      fallback_req  <= '0;
      skew_q        <= SK_IDLE;
      seen_mask     <= '0;
      skew_cnt      <= '0;
      skew_valid    <= 1'b0;
      skew_overflow <= 1'b0;
    end else begin
      am_ping_r     <= am_ping;
      lock_q        <= lock_d;
      good_cnt      <= good_d;
      bad_cnt       <= bad_d;
      fallback_req  <= fallback_d;
      skew_q        <= skew_d;
      seen_mask     <= seen_d;
      skew_cnt      <= skew_cnt_d;
      skew_valid    <= valid_d;
      skew_overflow <= overflow_d;
    end
  end

  // Last measured skew survives a word-lock drop; only srst clears it.
  always_ff @(posedge clk) begin
    if (srst)             skew_cycles <= '0;
    else if (word_locked) skew_cycles <= skew_cycles_d;
  end

  assign deskew_locked = (lock_q == LK_LOCKED);

endmodule

// File: tb/tb_deskew_nln.sv
`timescale 1ns/1ps
// Bench for deskew_nln: two instances (LOCK_CNT=1 and 3) share stimulus and are
// checked every cycle against a timestamp-based reference model.
module tb_deskew_nln;
  localparam int NL  = 4;
  localparam int GR  = 8;
  localparam int UNL = 2;

  logic       clk = 1'b0;
  logic       srst, word_locked;
  logic [3:0] am_ping;
  logic [3:0] fb  [2];
  logic       lk  [2];
  logic [7:0] skc [2];
  logic       sv  [2];
  logic       so  [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  deskew_nln #(.NUM_LANES(NL), .GRACE(GR), .LOCK_CNT(1), .UNLOCK_CNT(UNL)) u0 (
    .clk(clk), .srst(srst), .word_locked(word_locked), .am_ping(am_ping),
    .fallback_req(fb[0]), .deskew_locked(lk[0]), .skew_cycles(skc[0]),
    .skew_valid(sv[0]), .skew_overflow(so[0]));

  deskew_nln #(.NUM_LANES(NL), .GRACE(GR), .LOCK_CNT(3), .UNLOCK_CNT(UNL)) u1 (
    .clk(clk), .srst(srst), .word_locked(word_locked), .am_ping(am_ping),
    .fallback_req(fb[1]), .deskew_locked(lk[1]), .skew_cycles(skc[1]),
    .skew_valid(sv[1]), .skew_overflow(so[1]));

  always #5 clk = ~clk;

  // Reference model: pings are time-stamped; "recent" and skew are time differences.
  int         now = 0;
  logic [3:0] m_pend  [2];
  bit         m_have  [2][4];
  int         m_last  [2][4];
  bit         m_locked[2];
  int         m_streak[2];
  int         m_bad   [2];
  bit         m_open  [2];
  int         m_start [2];
  logic [3:0] m_seen  [2];
  logic [3:0] e_fb    [2];
  bit         e_val   [2];
  bit         e_ovf   [2];
  int         e_skc   [2];

  function automatic int lock_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void model_clear(int k, bit full);
    m_pend[k] = '0;
    for (int i = 0; i < 4; i++) m_have[k][i] = 0;
    m_locked[k] = 0;
    m_streak[k] = 0;
    m_bad[k]    = 0;
    m_open[k]   = 0;
    e_fb[k]     = '0;
    e_val[k]    = 0;
    e_ovf[k]    = 0;
    if (full) e_skc[k] = 0;
  endfunction

  function automatic void model_run(int k);
    logic [3:0] p, rec, bit_i;
    bit         lock_before, ev, al;
    int         el;
    p = m_pend[k];
    m_pend[k] = am_ping;
    for (int i = 0; i < 4; i++)
      rec[i] = m_have[k][i] && ((now - m_last[k][i]) <= GR);
    for (int i = 0; i < 4; i++)
      if (p[i]) begin
        m_have[k][i] = 1;
        m_last[k][i] = now;
      end
    lock_before = m_locked[k];
    e_fb[k] = '0;
    if (!lock_before)
      for (int i = 0; i < 4; i++) begin
        bit_i = 4'b0001 << i;
        if (rec[i] && !p[i] && ((p & ~bit_i) != 4'b0000)) e_fb[k][i] = 1'b1;
      end
    ev = (p != 4'b0000);
    al = (p == 4'b1111);
    if (!lock_before) begin
      if (al) begin
        m_streak[k]++;
        if (m_streak[k] >= lock_of(k)) begin
          m_locked[k] = 1;
          m_streak[k] = 0;
        end
      end else if (ev) m_streak[k] = 0;
    end else begin
      if (al) m_bad[k] = 0;
      else if (ev) begin
        m_bad[k]++;
        if (m_bad[k] >= UNL) begin
          m_locked[k] = 0;
          m_bad[k]    = 0;
          m_streak[k] = 0;
        end
      end
    end
    e_val[k] = 0;
    e_ovf[k] = 0;
    if (!m_open[k]) begin
      if (al) begin
        e_val[k] = 1;
        e_skc[k] = 0;
      end else if (ev) begin
        m_open[k]  = 1;
        m_start[k] = now;
        m_seen[k]  = p;
      end
    end else begin
      m_seen[k] = m_seen[k] | p;
      el = now - m_start[k];
      if (m_seen[k] == 4'b1111) begin
        e_val[k]  = 1;
        e_skc[k]  = el;
        m_open[k] = 0;
      end else if (el >= GR) begin
        e_val[k]  = 1;
        e_ovf[k]  = 1;
        e_skc[k]  = GR;
        m_open[k] = 0;
      end
    end
  endfunction

  function automatic void model_step();
    now++;
    for (int k = 0; k < 2; k++) begin
      if (srst)              model_clear(k, 1);
      else if (!word_locked) model_clear(k, 0);
      else                   model_run(k);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.fallback_req", k),  32'(fb[k]),  32'(e_fb[k]));
        chk($sformatf("u%0d.deskew_locked", k), 32'(lk[k]),  32'(m_locked[k]));
        chk($sformatf("u%0d.skew_valid", k),    32'(sv[k]),  32'(e_val[k]));
        chk($sformatf("u%0d.skew_overflow", k), 32'(so[k]),  32'(e_ovf[k]));
        chk($sformatf("u%0d.skew_cycles", k),   32'(skc[k]), 32'(e_skc[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] p);
    am_ping = p;
    tick();
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000);
  endtask

  initial begin
    int r;
    srst = 1'b1;
    word_locked = 1'b1;
    am_ping = '0;
    for (int i = 0; i < 3; i++) tick();
    cmp_en = 1;
    srst = 1'b0;
    chk("reset lock", 32'(lk[0]), 0);
    chk("reset fallback", 32'(fb[0]), 0);
    chk("reset skew_valid", 32'(sv[0]), 0);
    chk("reset skew_cycles", 32'(skc[0]), 0);

    // All lanes aligned: lock in two cycles for LOCK_CNT=1 only.
    drive(4'b1111); drive(4'b0000);
    chk("aligned lock u0", 32'(lk[0]), 1);
    chk("aligned lock u1", 32'(lk[1]), 0);
    chk("aligned skew_valid", 32'(sv[0]), 1);
    chk("aligned skew_cycles", 32'(skc[0]), 0);
    chk("aligned overflow", 32'(so[0]), 0);
    chk("aligned fallback", 32'(fb[0]), 0);
    drive(4'b0000);
    chk("skew_valid pulse", 32'(sv[0]), 0);

    // Lane 2 early by 3 cycles.
    srst = 1'b1; tick(); srst = 1'b0;
    drive(4'b0100); drive(4'b0000); drive(4'b0000); drive(4'b1011); drive(4'b0000);
    chk("early fallback", 32'(fb[0]), 32'h4);
    chk("early skew_cycles", 32'(skc[0]), 3);
    chk("early skew_valid", 32'(sv[0]), 1);
    chk("early lock", 32'(lk[0]), 0);
    drive(4'b0000);
    chk("fallback one cycle", 32'(fb[0]), 0);

    // Two misaligned events drop lock; an aligned one in between keeps it.
    drive(4'b1111); drive(4'b0000);
    chk("relock", 32'(lk[0]), 1);
    drive(4'b0111); drive(4'b0000);
    chk("one bad keeps lock", 32'(lk[0]), 1);
    drive(4'b0111); drive(4'b0000);
    chk("two bad drop lock", 32'(lk[0]), 0);
    flush(12);
    drive(4'b1111); drive(4'b0000);
    drive(4'b0111); drive(4'b0000); drive(4'b1111); drive(4'b0000);
    drive(4'b0111); drive(4'b0000);
    chk("interleaved aligned keeps lock", 32'(lk[0]), 1);
    flush(12);

    // Lane 1 never pings: round overflows after GRACE cycles.
    drive(4'b1101);
    for (int k = 1; k <= 9; k++) begin
      drive(4'b0000);
      if (k == 8) chk("overflow not early", 32'(sv[0]), 0);
    end
    chk("overflow valid", 32'(sv[0]), 1);
    chk("overflow flag", 32'(so[0]), 1);
    chk("overflow cycles", 32'(skc[0]), 8);
    chk("overflow no slip", 32'(fb[0]), 0);

    // LOCK_CNT=3 needs three consecutive aligned events.
    srst = 1'b1; tick(); srst = 1'b0;
    drive(4'b1111); drive(4'b0000); drive(4'b1111); drive(4'b0000);
    drive(4'b0001); drive(4'b0000);
    drive(4'b1111); drive(4'b0000); drive(4'b1111); drive(4'b0000);
    chk("lock3 after two", 32'(lk[1]), 0);
    drive(4'b1111); drive(4'b0000);
    chk("lock3 after three", 32'(lk[1]), 1);

    // srst while locked with a round open.
    drive(4'b0011); drive(4'b0000);
    am_ping = 4'b1100; srst = 1'b1; tick(); srst = 1'b0;
    chk("srst lock", 32'(lk[0]), 0);
    chk("srst fallback", 32'(fb[0]), 0);
    chk("srst skew_valid", 32'(sv[0]), 0);
    chk("srst skew_cycles", 32'(skc[0]), 0);
    am_ping = 4'b0000; tick();
    chk("srst no late valid", 32'(sv[0]), 0);
    drive(4'b1111); drive(4'b0000);
    chk("srst recover", 32'(lk[0]), 1);

    // word_locked drop while locked with a round open.
    drive(4'b0011); drive(4'b0000);
    am_ping = 4'b1100; word_locked = 1'b0; tick(); word_locked = 1'b1;
    chk("wl drop lock", 32'(lk[0]), 0);
    chk("wl drop valid", 32'(sv[0]), 0);
    am_ping = 4'b0000; tick();
    chk("wl drop no late valid", 32'(sv[0]), 0);
    drive(4'b1111); drive(4'b0000);
    chk("wl recover", 32'(lk[0]), 1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      srst        = ($urandom_range(0, 399) == 0);
      word_locked = ($urandom_range(0, 249) != 0);
      r = $urandom_range(0, 99);
      if (r < 65)      am_ping = 4'b0000;
      else if (r < 78) am_ping = 4'b1111;
      else             am_ping = 4'($urandom_range(1, 14));
      tick();
    end
    srst = 1'b0;
    word_locked = 1'b1;
    am_ping = '0;
    tick();
    @(negedge clk);
    #1;
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
